bridge_occupancy_counter: RTL
=============================

# bridge_occupancy_counter

Multi-lane vehicle occupancy counter for the drawbridge controller. It counts vehicles entering and leaving the deck across several sensor lanes and clamps the count to a configured capacity. It reports occupied, full and error status, and grants bridge-raise permission only after the deck has stayed empty for a programmable hold time. It sits between the lane sensor inputs and the bridge sequencing FSM.

## Interface
Parameters:
- LANES, 2: number of entry/exit sensor pairs (1..8)
- WIDTH, 4: width of the occupancy count
- CAPACITY, 10: maximum legal count; must be ≤ 2^WIDTH−1
- HOLD_CYCLES, 4: consecutive empty cycles required before RaiseOk (≥1)

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- CarIn  in  LANES  entry sensors, level; one vehicle per rising edge per lane
- CarOut  in  LANES  exit sensors, level; one vehicle per rising edge per lane
- Clear  in  1  synchronous clear of count and sticky errors
- Count  out  WIDTH  current occupancy
- Occupied  out  1  Count ≠ 0
- Full  out  1  Count == CAPACITY
- OverflowErr  out  1  sticky; an entry was dropped at capacity
- UnderflowErr  out  1  sticky; an exit was seen with an empty deck
- RaiseOk  out  1  deck empty for HOLD_CYCLES cycles

## Operation
- Edge detect: each sensor bit has a previous-sample register that resets to 1, so a sensor already high at reset release is not counted. An event is current sample 1 with previous sample 0.
- Per cycle: ins = popcount of CarIn events, outs = popcount of CarOut events. raw = Count + ins − outs, computed signed in WIDTH+2 bits.
- Clamping:
  - raw < 0: Count ← 0 and UnderflowErr ← 1.
  - raw > CAPACITY: Count ← CAPACITY and OverflowErr ← 1.
  - Otherwise Count ← raw.
- Simultaneous in and out events, on the same lane or different lanes, net out within the same cycle. Underflow is judged only on the net result: Count 0 with 1 in and 1 out gives 0 and no error.
- Clear = 1:
  - Count ← 0; both errors ← 0.
  - Sensor events that cycle are discarded, but the previous-sample registers still update.
  - FSM → HOLD with the timer at 0.
  - Clear overrides all other updates.
- Occupied and Full are registered outputs, decoded from the next Count value. They therefore change on the same edge as Count.
- Raise FSM, with timer width clog2(HOLD_CYCLES+1):
  - BUSY: RaiseOk = 0. Goes to HOLD with timer 0 when next Count == 0.
  - HOLD: RaiseOk = 0. The timer increments each cycle while next Count == 0. Goes to READY when the timer reaches HOLD_CYCLES−1 and next Count == 0. Goes to BUSY if next Count ≠ 0.
  - READY: RaiseOk = 1. Goes to BUSY when next Count ≠ 0, with RaiseOk dropping on that same edge.

## Timing
- Reset values:
  - Count = 0, Occupied = 0, Full = 0, OverflowErr = 0, UnderflowErr = 0, RaiseOk = 0.
  - FSM = HOLD, timer = 0.
  - Previous-sample registers all 1.
- Latency: a sensor that is high at rising edge k, after being low at edge k−1, updates Count and all flags after edge k, i.e. one cycle.
- RaiseOk rises after the HOLD_CYCLES-th consecutive edge at which Count is 0. After reset release with no traffic, RaiseOk is high after edge HOLD_CYCLES.
- A held-high sensor counts once. Re-arming requires at least one sampled low cycle.
- Asserting Reset mid-operation returns every register to its reset value immediately, regardless of Clk.

## Configuration
- BRIDGE_OCC_SYNC_EN defined:
  - CarIn and CarOut each pass through a two-flop synchronizer, reset to 1, before edge detection.
  - Latency rises to 3 cycles from the first sampling edge.
  - Clear is not synchronized.
- BRIDGE_OCC_SYNC_EN undefined: sensors feed edge detection directly, with the 1-cycle latency stated in Timing.

## Test plan
All scenarios use LANES=2, WIDTH=4, CAPACITY=10, HOLD_CYCLES=4, with the macro undefined.
- Reset release, no traffic:
  - Count = 0 throughout.
  - RaiseOk = 0 after edges 1–3, and 1 after edge 4.
- Single-lane counting:
  - Three pulses on CarIn[0] → Count 3, Occupied 1, RaiseOk 0.
  - Then three pulses on CarOut[1] → Count 0, Occupied 0.
  - RaiseOk returns to 1 four edges after Count reaches 0.
- Simultaneous events: at Count 5, CarIn = 2'b11 and CarOut = 2'b01 on the same edge → Count 6.
  - At Count 0, CarIn[0] and CarOut[0] together → Count 0, no UnderflowErr.
- Saturation: twelve entry events → Count 10, Full 1, OverflowErr 1.
  - One exit → Count 9, Full 0, OverflowErr stays 1.
  - Clear → Count 0, OverflowErr 0.
- Underflow, held sensors, and reset:
  - At Count 0, a pulse on CarOut[1] → Count 0, UnderflowErr 1.
  - CarIn[0] held high for 20 cycles → Count increments by exactly 1.
  - Sensor high across reset release → no count.
  - Reset asserted mid-count at Count 7 → all outputs 0 immediately.

Source files
------------

// File: rtl/bridge_occupancy_counter.sv
// Multi-lane drawbridge deck occupancy counter with clamping, sticky errors and an
// empty-hold raise permission. Define BRIDGE_OCC_SYNC_EN to add two-flop sensor synchronizers.
module bridge_occupancy_counter #(
  parameter int LANES       = 2,
  parameter int WIDTH       = 4,
  parameter int CAPACITY    = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] CarIn,
  input  logic [LANES-1:0] CarOut,
  input  logic             Clear,
  output logic [WIDTH-1:0] Count,
  output logic             Occupied,
  output logic             Full,
  output logic             OverflowErr,
  output logic             UnderflowErr,
  output logic             RaiseOk
);

  localparam int RW = WIDTH + 2;
  localparam int TW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_BUSY,
    ST_HOLD,
    ST_READY
  } state_e;

  logic [LANES-1:0] in_s;
  logic [LANES-1:0] out_s;

`ifdef BRIDGE_OCC_SYNC_EN
  logic [LANES-1:0] in_meta_q;
  logic [LANES-1:0] in_sync_q;
  logic [LANES-1:0] out_meta_q;
  logic [LANES-1:0] out_sync_q;

  // Synchronizers reset high so a sensor already active at reset release never fires.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      in_meta_q  <= '1;
      in_sync_q  <= '1;
      out_meta_q <= '1;
      out_sync_q <= '1;
    end else begin
      in_meta_q  <= CarIn;
      in_sync_q  <= in_meta_q;
      out_meta_q <= CarOut;
      out_sync_q <= out_meta_q;
    end
  end

  assign in_s  = in_sync_q;
  assign out_s = out_sync_q;
`else
  assign in_s  = CarIn;
  assign out_s = CarOut;
`endif

  logic [LANES-1:0] prev_in_q;
  logic [LANES-1:0] prev_out_q;
  logic [LANES-1:0] in_evt;
  logic [LANES-1:0] out_evt;

  assign in_evt  = in_s & ~prev_in_q;
  assign out_evt = out_s & ~prev_out_q;

  logic [WIDTH-1:0]     count_q,  count_d;
  logic                 ovf_q,    ovf_d;
  logic                 unf_q,    unf_d;
  logic signed [RW-1:0] ins;
  logic signed [RW-1:0] outs;
  logic signed [RW-1:0] raw;
  logic                 next_zero;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ins  = '0;
    outs = '0;
    for (int i = 0; i < LANES; i++) begin
      ins  = ins  + RW'(in_evt[i]);
      outs = outs + RW'(out_evt[i]);
    end
    raw = $signed(RW'(count_q)) + ins - outs;

    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (Clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (raw < 0) begin
      count_d = '0;
      unf_d   = 1'b1;
    end else if (raw > $signed(RW'(CAPACITY))) begin
      count_d = WIDTH'(CAPACITY);
      ovf_d   = 1'b1;
    end else begin
      count_d = raw[WIDTH-1:0];
    end
  end

  assign next_zero = (count_d == '0);

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          occupied_q;
  logic          full_q;
  logic          raise_q;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_in_q  <= '1;
      prev_out_q <= '1;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      occupied_q <= 1'b0;
      full_q     <= 1'b0;
      state_q    <= ST_HOLD;
      timer_q    <= '0;
      raise_q    <= 1'b0;
    end else begin
      prev_in_q  <= in_s;
      prev_out_q <= out_s;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      occupied_q <= !next_zero;
      full_q     <= (count_d == WIDTH'(CAPACITY));

      // Flags and RaiseOk are decoded from the next count so they move with Count.
      if (Clear) begin
        state_q <= ST_HOLD;
        timer_q <= '0;
        raise_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_BUSY: begin
            raise_q <= 1'b0;
            if (next_zero) begin
              state_q <= ST_HOLD;
              timer_q <= '0;
            end
          end
          ST_HOLD: begin
            if (!next_zero) begin
              state_q <= ST_BUSY;
              raise_q <= 1'b0;
            end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
              state_q <= ST_READY;
              raise_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          ST_READY: begin
            if (!next_zero) begin
              state_q <= ST_BUSY;
              raise_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_HOLD;
            timer_q <= '0;
            raise_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Count        = count_q;
  assign Occupied     = occupied_q;
  assign Full         = full_q;
  assign OverflowErr  = ovf_q;
  assign UnderflowErr = unf_q;
  assign RaiseOk      = raise_q;

endmodule
